wb_write_sequencer: RTL and testbench
=====================================

# wb_write_sequencer

- Writeback-side sequencer between the MEM/WB pipeline register and the register file write port.
- Buffers retiring results in a small FIFO and drives the 16-bit write port one strobe per cycle.
- Splits 32-bit writes to SP/PC (addresses 8/9) into low-half then high-half strobes via `dirc_byte`.
- Forwards still-pending data so decode never reads a stale value.

## Interface
Parameters:
- DATA_W, 16, register-file write-port width
- ADDR_W, 4, register address width
- DEPTH, 2, FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  MEM/WB result valid
- in_ready  out  1  sequencer accepts; transfer when in_valid && in_ready
- in_addr  in  ADDR_W  destination: 0–7 general, 8–9 SP/PC, ≥10 flags
- in_data  in  2*DATA_W  result; only [15:0] used unless wide
- in_wide  in  1  32-bit write; honoured only for addr 8/9
- rf_write_enable  out  1  active-low write strobe to register file
- rf_write_addr  out  ADDR_W  write address
- rf_write_data  out  DATA_W  write data
- rf_dirc_byte  out  1  half select: 0 = [15:0], 1 = [31:16]
- busy  out  1  FIFO non-empty or strobe presented
- fwd_addr1, fwd_addr2  in  ADDR_W  decode read addresses
- fwd_dirc  in  1  half requested for addr 8/9
- fwd_hit1, fwd_hit2  out  1  pending write matches
- fwd_data1, fwd_data2  out  DATA_W  forwarded value

## Operation
- FIFO entries hold {addr, data[31:0], wide}. `wide` is cleared on push when addr ∉ {8,9}.
- `in_ready` = !full; it is registered from occupancy. There is no same-cycle push-when-full, even if a pop occurs that cycle.
- Presentation register drives `rf_*`. FSM states:
  - IDLE: no strobe presented.
  - WR_LO: presents data[15:0] with dirc_byte=0.
  - WR_HI: presents data[31:16] with dirc_byte=1.
- Each edge, the FSM loads the next presentation:
  - If WR_LO of a wide entry is presented: go to WR_HI, same entry.
  - Else if FIFO non-empty: pop head, go to WR_LO.
  - Else: go to IDLE.
- Narrow entries take one strobe; wide entries take two consecutive strobes. There are no bubbles while data is pending.
- `rf_dirc_byte` = 0 for addr <8 or ≥10.
- IDLE drives rf_write_enable=1, addr=0, data=0, dirc=0.
- Forwarding is combinational. Search order is youngest first: FIFO tail→head, then the presentation register.
  - Wide entry match: data half selected by `fwd_dirc`.
  - Narrow entry to 8/9: hits only when fwd_dirc=0.
  - A wide entry in WR_HI whose low half is already written still forwards both halves.
- No hit: hit=0, data=0.

## Timing
- Reset (rst high at an edge): FIFO empty, state IDLE, rf_write_enable=1, rf_write_addr/data/dirc=0, busy=0, fwd_hit*=0. `in_ready`=0 while rst is high and 1 in the first cycle after.
- Latency:
  - Entry accepted at edge E into an empty sequencer → strobe presented in cycle E..E+1; the register file commits at edge E+1.
  - Wide high half is committed at edge E+2.
- Throughput: one narrow write per cycle; a wide write occupies two cycles.
- Simultaneous push and pop: allowed when not full; occupancy is unchanged.
- Pointer wrap-around: modulo DEPTH.
- Reset mid-wide (rst high during WR_LO): the high half is never strobed; the register file keeps only the low half. This is accepted behaviour.
- Forwarded data is valid the same cycle as `fwd_addr*`. The presented entry stays forwardable until its commit edge, which covers the register file's negedge-read/posedge-write window.

## Structure
- Package `wb_pkg`:
  - Constants REG_SP_ADDR=4'd8, REG_PC_ADDR=4'd9, REG_FLAGS_ADDR=4'd10.
  - State enum {IDLE, WR_LO, WR_HI}.
  - Entry struct {addr, data, wide}.
- Sub-module `wb_fifo`: parameterised DEPTH FIFO exposing all entries for forwarding search.
- FSM, presentation register and forwarding mux live in the top module.

## Test plan
- Reset: hold rst 2 cycles → rf_write_enable=1, busy=0, in_ready=0; in_ready=1 the cycle after rst falls.
- Narrow: push addr 3, data 0x0000_1234 → next cycle exactly one strobe: enable=0, addr 3, data 0x1234, dirc 0; then IDLE.
- Wide: push addr 9, data 0xABCD_1234, wide=1 → strobe 0x1234 dirc 0, then strobe 0xABCD dirc 1; wide=1 to addr 2 → single strobe 0x1234.
- Back-pressure: push wide addr 8, then narrow addr 1, then narrow addr 4 back to back → in_ready drops at full; strobe order 8-lo, 8-hi, 1, 4; nothing lost or duplicated.
- Forwarding:
  - Push addr 5 = 0x11, then addr 5 = 0x22; fwd_addr1=5 → hit, 0x0022 until the last strobe commits, then hit=0.
  - Wide addr 8 = 0x5555_AAAA with fwd_dirc=1 → 0x5555.
- Reset mid-wide: assert rst during WR_LO of addr 9 → no dirc=1 strobe; all outputs at reset values the next cycle.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback sequencer: register map, FSM states,
// the buffered entry layout and the forwarding match rules.
package wb_pkg;

  localparam int WB_ADDR_W = 4;
  localparam int WB_DATA_W = 16;

  localparam logic [WB_ADDR_W-1:0] REG_SP_ADDR    = 4'd8;
  localparam logic [WB_ADDR_W-1:0] REG_PC_ADDR    = 4'd9;
  localparam logic [WB_ADDR_W-1:0] REG_FLAGS_ADDR = 4'd10;

  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} wb_state_e;

  typedef struct packed {
    logic [WB_ADDR_W-1:0]   addr;
    logic [2*WB_DATA_W-1:0] data;
    logic                   wide;
  } wb_entry_t;

  function automatic logic is_wide_reg(input logic [WB_ADDR_W-1:0] a);
    return (a == REG_SP_ADDR) || (a == REG_PC_ADDR);
  endfunction

  // A narrow write to SP/PC only covers the low half, so it cannot answer a high-half read.
  function automatic logic entry_hits(input wb_entry_t e, input logic [WB_ADDR_W-1:0] a,
                                      input logic dirc);
    return (e.addr == a) && (e.wide || !dirc || !is_wide_reg(e.addr));
  endfunction

  function automatic logic [WB_DATA_W-1:0] entry_half(input wb_entry_t e, input logic dirc);
    return (e.wide && dirc) ? e.data[2*WB_DATA_W-1:WB_DATA_W] : e.data[WB_DATA_W-1:0];
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending writeback entries; every slot is exposed in age order
// (index 0 = head/oldest) so the forwarding search can scan them. No internal overflow guard.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output wb_entry_t                age_entry [DEPTH]
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Power-of-two depth lets the pointer sum wrap naturally.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_entry[i] = mem_q[rd_ptr_q + PTR_W'(i)];
    end
  end

  assign count = count_q;

endmodule

// File: rtl/wb_write_sequencer.sv
// Drains MEM/WB results into the register-file write port, one active-low strobe per cycle,
// splitting SP/PC 32-bit writes into low then high halves; in_ready is registered !full.
module wb_write_sequencer
  import wb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [2*DATA_W-1:0] in_data,
  input  logic                in_wide,
  output logic                rf_write_enable,
  output logic [ADDR_W-1:0]   rf_write_addr,
  output logic [DATA_W-1:0]   rf_write_data,
  output logic                rf_dirc_byte,
  output logic                busy,
  input  logic [ADDR_W-1:0]   fwd_addr1,
  input  logic [ADDR_W-1:0]   fwd_addr2,
  input  logic                fwd_dirc,
  output logic                fwd_hit1,
  output logic                fwd_hit2,
  output logic [DATA_W-1:0]   fwd_data1,
  output logic [DATA_W-1:0]   fwd_data2
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_state_e        state_q, state_d;
  wb_entry_t        pres_q, pres_d;
  logic             in_ready_q, in_ready_d;
  wb_entry_t        in_entry;
  logic             accept, fifo_push, fifo_pop;
  logic [CNT_W-1:0] fifo_count;
  wb_entry_t        fifo_age [DEPTH];

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_entry (in_entry),
    .pop        (fifo_pop),
    .count      (fifo_count),
    .age_entry  (fifo_age)
  );

  always_comb begin
    in_entry.addr = in_addr;
    in_entry.data = in_data;
    in_entry.wide = in_wide && is_wide_reg(in_addr);
    accept        = in_valid && in_ready_q;

    state_d   = IDLE;
    pres_d    = '0;
    fifo_push = accept;
    fifo_pop  = 1'b0;
    if (state_q == WR_LO && pres_q.wide) begin
      state_d = WR_HI;
      pres_d  = pres_q;
    end else if (fifo_count != '0) begin
      fifo_pop = 1'b1;
      state_d  = WR_LO;
      pres_d   = fifo_age[0];
    end else if (accept) begin
      // Empty and free: the incoming result skips the FIFO and strobes next cycle.
      fifo_push = 1'b0;
      state_d   = WR_LO;
      pres_d    = in_entry;
    end

    in_ready_d = (fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop)) != CNT_W'(DEPTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pres_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pres_q     <= pres_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = (fifo_count != '0) || (state_q != IDLE);

  always_comb begin
    rf_write_enable = 1'b1;
    rf_write_addr   = '0;
    rf_write_data   = '0;
    rf_dirc_byte    = 1'b0;
    if (state_q != IDLE) begin
      rf_write_enable = 1'b0;
      rf_write_addr   = pres_q.addr;
      rf_write_data   = entry_half(pres_q, state_q == WR_HI);
      rf_dirc_byte    = (state_q == WR_HI) && (pres_q.addr >= REG_SP_ADDR) &&
                        (pres_q.addr < REG_FLAGS_ADDR);
    end
  end

  // Oldest first so that younger matches overwrite: presentation, then FIFO head to tail.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    if (state_q != IDLE) begin
      if (entry_hits(pres_q, fwd_addr1, fwd_dirc)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = entry_half(pres_q, fwd_dirc);
      end
      if (entry_hits(pres_q, fwd_addr2, fwd_dirc)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = entry_half(pres_q, fwd_dirc);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < fifo_count) begin
        if (entry_hits(fifo_age[i], fwd_addr1, fwd_dirc)) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = entry_half(fifo_age[i], fwd_dirc);
        end
        if (entry_hits(fifo_age[i], fwd_addr2, fwd_dirc)) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = entry_half(fifo_age[i], fwd_dirc);
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_write_sequencer.sv
// Randomized bench: accepted writes feed a strobe scoreboard and a pending-write model;
// a negedge monitor checks strobes, handshake, busy and forwarding against them.
module tb_wb_write_sequencer;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_wide, fwd_dirc;
  logic [3:0]  in_addr, fwd_addr1, fwd_addr2, rf_write_addr;
  logic [31:0] in_data;
  logic        rf_write_enable, rf_dirc_byte, busy, fwd_hit1, fwd_hit2;
  logic [15:0] rf_write_data, fwd_data1, fwd_data2;

  wb_write_sequencer #(.DATA_W(16), .ADDR_W(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .in_wide(in_wide),
    .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data), .rf_dirc_byte(rf_dirc_byte), .busy(busy),
    .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2), .fwd_dirc(fwd_dirc),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
    logic        dirc;
  } strobe_t;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic        wide;
    int          left;
  } pend_t;

  strobe_t    exp_q[$];
  pend_t      acc_q[$];
  pend_t      pend[$];
  int         total = 0;
  int         bad = 0;
  logic       rst_prev = 1'b1;
  logic       fwd_rand = 1'b1;
  logic [3:0] last_addr = 4'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Youngest pending write wins; SP/PC high half only comes from a wide write.
  function automatic void fwd_model(input logic [3:0] a, input logic dirc,
                                    output logic hit, output logic [15:0] d);
    hit = 1'b0;
    d   = 16'h0;
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (pend[i].addr == a && (pend[i].wide || !dirc || !(a == 4'd8 || a == 4'd9))) begin
        hit = 1'b1;
        d   = (pend[i].wide && dirc) ? pend[i].data[31:16] : pend[i].data[15:0];
        break;
      end
    end
  endfunction

  always @(negedge clk) begin : monitor
    logic    h;
    logic [15:0] d;
    int      fifo_n;
    strobe_t s;
    pend_t   p;
    fifo_n = (pend.size() > 0) ? pend.size() - 1 : 0;
    chk("busy", 32'(busy), 32'(pend.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(!rst_prev && fifo_n < DEPTH));
    fwd_model(fwd_addr1, fwd_dirc, h, d);
    chk("fwd_hit1", 32'(fwd_hit1), 32'(h));
    chk("fwd_data1", 32'(fwd_data1), 32'(d));
    fwd_model(fwd_addr2, fwd_dirc, h, d);
    chk("fwd_hit2", 32'(fwd_hit2), 32'(h));
    chk("fwd_data2", 32'(fwd_data2), 32'(d));
    if (!rf_write_enable) begin
      chk("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        s = exp_q.pop_front();
        chk("strobe_addr", 32'(rf_write_addr), 32'(s.addr));
        chk("strobe_data", 32'(rf_write_data), 32'(s.data));
        chk("strobe_dirc", 32'(rf_dirc_byte), 32'(s.dirc));
      end
      if (pend.size() != 0) begin
        p = pend.pop_front();
        p.left--;
        if (p.left > 0) pend.push_front(p);
      end
    end else begin
      chk("no_bubble", 32'(pend.size()), 32'd0);
      chk("idle_outputs", {11'h0, rf_dirc_byte, rf_write_addr, rf_write_data}, 32'd0);
    end
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      pend.delete();
    end else begin
      while (acc_q.size() != 0) pend.push_back(acc_q.pop_front());
    end
    rst_prev = rst;
  end

  task automatic rand_fwd();
    if (fwd_rand) begin
      fwd_addr1 = ($urandom_range(0, 1) == 1) ? last_addr : 4'($urandom_range(0, 15));
      fwd_addr2 = 4'($urandom_range(7, 10));
      fwd_dirc  = 1'($urandom_range(0, 1));
    end
  endtask

  // Called and returns at posedge+1; holds the request until accepted.
  task automatic send(input logic [3:0] a, input logic [31:0] d, input logic w);
    int    n;
    logic  wide;
    pend_t p;
    n        = 0;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_wide  = w;
    rand_fwd();
    #1;
    while (!in_ready && n <= 50) begin
      n++;
      @(posedge clk);
      #1;
      rand_fwd();
      #1;
    end
    chk("accept_timeout", 32'(in_ready), 32'd1);
    if (in_ready) begin
      wide = w && (a == 4'd8 || a == 4'd9);
      exp_q.push_back('{addr: a, data: d[15:0], dirc: 1'b0});
      if (wide) exp_q.push_back('{addr: a, data: d[31:16], dirc: 1'b1});
      p.addr = a;
      p.data = d;
      p.wide = wide;
      p.left = wide ? 2 : 1;
      acc_q.push_back(p);
      last_addr = a;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      rand_fwd();
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_addr   = 4'd0;
    in_data   = 32'd0;
    in_wide   = 1'b0;
    fwd_addr1 = 4'd0;
    fwd_addr2 = 4'd0;
    fwd_dirc  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    send(4'd3, 32'h0000_1234, 1'b0);
    idle(3);
    send(4'd9, 32'hABCD_1234, 1'b1);
    idle(3);
    send(4'd2, 32'hABCD_1234, 1'b1);
    idle(3);

    send(4'd8, 32'h8888_0808, 1'b1);
    send(4'd9, 32'h9999_0909, 1'b1);
    send(4'd1, 32'h0000_0101, 1'b0);
    send(4'd4, 32'h0000_0404, 1'b0);
    send(4'd8, 32'h7777_0707, 1'b1);
    idle(8);

    fwd_rand  = 1'b0;
    fwd_addr1 = 4'd5;
    fwd_addr2 = 4'd8;
    fwd_dirc  = 1'b0;
    send(4'd5, 32'h0000_0011, 1'b0);
    send(4'd5, 32'h0000_0022, 1'b0);
    idle(4);
    fwd_dirc = 1'b1;
    send(4'd8, 32'h5555_AAAA, 1'b1);
    idle(4);
    fwd_rand = 1'b1;

    send(4'd9, 32'hDEAD_BEEF, 1'b1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(3);

    for (int it = 0; it < 400; it++) begin
      if (it == 200) begin
        send(4'd8, 32'($urandom), 1'b1);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
      end
      if ($urandom_range(0, 3) != 0) begin
        send(($urandom_range(0, 2) == 0) ? 4'($urandom_range(8, 9)) : 4'($urandom_range(0, 15)),
             32'($urandom), 1'($urandom_range(0, 1)));
      end else begin
        idle($urandom_range(1, 3));
      end
    end

    idle(10);
    chk("drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
